// File: rtl/ps2_keyboard_rx_pkg.sv
// rtl/ps2_keyboard_rx_pkg.sv - shared PS/2 receiver state encodings, frame size and defaults
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS      = 8;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_TIMEOUT_CYC = 5000;

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - synchronous show-ahead FIFO that drops pushes when full
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop && !empty;
    // A same-cycle pop frees the slot, so a push against a full FIFO still lands.
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && !wr_en;

    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with scancode FIFO
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    BIT_LAST = 3'(FRAME_BITS - 1);

    logic       clk_s1, clk_s2, clk_s3;
    logic       dat_s1, dat_s2;
    logic       fall;

    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic [TW-1:0] tmo;
    logic       frame_good;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_drop;

    // Flops come out of reset at 1 (idle bus) so no phantom falling edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall       = clk_s3 && !clk_s2;
    assign frame_good = dat_s2 && (^{shreg, par_bit});
    assign push       = fall && (state == ST_STOP) && frame_good;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tmo       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (fall || state == ST_IDLE || tmo == TMO_LAST) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + TW'(1);
            end

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        frame_err <= !frame_good;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE && tmo == TMO_LAST) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - randomized self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int exp_err = 0;
    logic exp_ovf = 1'b0;
    logic [7:0] exp_q[$];

    ps2_keyboard_rx #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    // Frame layout: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input int kind);
        logic par;
        logic stp;
        par = ~(^d);
        stp = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) stp = 1'b0;
        return {stp, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk) ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Reference: a good frame joins the queue unless it already holds DEPTH bytes.
    task automatic model_frame(input logic [7:0] d, input int kind);
        if (kind != 0) begin
            exp_err++;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int kind);
        send_bits(make_frame(d, kind), 11);
        model_frame(d, kind);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out_data, e);
            out_ready = 1'b1;
            @(negedge clk) out_ready = 1'b0;
        end
        @(negedge clk);
        check({tag, "_empty"}, out_valid, 0);
    endtask

    initial begin
        logic [10:0] fr;
        int k;
        int nf;
        int kind;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_err", frame_err, 0);

        // Good 0x1C with exact visibility timing on the stop edge.
        fr = make_frame(8'h1C, 0);
        check("par_1c", fr[9], 0);
        send_bits(fr, 10);
        @(negedge clk) ps2_data = fr[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stop_edge_valid", out_valid, 0);
        @(negedge clk);
        check("after_stop_valid", out_valid, 1);
        check("after_stop_data", out_data, 8'h1C);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        exp_q.push_back(8'h1C);
        drain("good1c");
        check("good1c_err", err_seen, exp_err);

        // Bad parity.
        send_frame(8'h1C, 1);
        check("badpar_valid", out_valid, 0);
        check("badpar_err", err_seen, exp_err);

        // Two frames held, then read in order.
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        repeat (20) @(negedge clk);
        check("hold_data", out_data, 8'hF0);
        drain("two");

        // Overflow at the ninth frame.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0);
            check($sformatf("ovf_after_%0d", i), overflow, exp_ovf);
        end
        drain("ovf");
        check("ovf_sticky", overflow, 1);
        do_reset();
        @(negedge clk);
        check("ovf_cleared", overflow, 0);

        // Timeout after start + 4 data bits.
        fr = make_frame(8'h55, 0);
        send_bits(fr, 4);
        @(negedge clk) ps2_data = fr[4];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        k = 0;
        while (k < TMO + 40 && !frame_err) begin
            @(negedge clk);
            k++;
            if (k == HALF) ps2_clk = 1'b1;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        exp_err++;
        check("tmo_window", (k >= TMO && k <= TMO + 4), 1);
        repeat (20) @(negedge clk);
        check("tmo_err", err_seen, exp_err);
        check("tmo_valid", out_valid, 0);
        send_frame(8'h32, 0);
        drain("after_tmo");

        // Reset mid-frame.
        send_bits(make_frame(8'hA5, 0), 5);
        do_reset();
        repeat (TMO + 20) @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_err", err_seen, exp_err);
        send_frame(8'h1C, 0);
        drain("midrst");

        // Randomized batches with mixed good and malformed frames.
        for (int b = 0; b < 4; b++) begin
            nf = $urandom_range(1, 10);
            for (int i = 0; i < nf; i++) begin
                d = 8'($urandom_range(0, 255));
                kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                send_frame(d, kind);
            end
            check($sformatf("rnd%0d_ovf", b), overflow, exp_ovf);
            check($sformatf("rnd%0d_err", b), err_seen, exp_err);
            drain($sformatf("rnd%0d", b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
